layer_2_mac_sequencer: RTL and testbench

LAYER_2_MAC_SEQUENCER -- requirements
Module: layer_2_mac_sequencer

---
 rtl/layer_2_mac_sequencer.sv | 159 +++++++++++++++
 tb/tb_layer_2_mac_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_2_mac_sequencer.sv
// layer_2_mac_sequencer
//
// Sequential evaluation of the second (output) layer of a small neural net.
// One signed weight x hidden multiplier is shared across all N*M products.
// Each output neuron j takes N MAC cycles and then one BIAS cycle. The
// results go to staging slots and are copied together to activation_vector
// when the FSM enters DONE.
//
// Optional feature: define LAYER2_RELU_EN to clamp negative biased sums to 0
// before they are stored.
//
// Ports:
//   clk                 - single clock, rising edge
//   rst_n               - asynchronous, active-low reset
//   start               - request one evaluation (only accepted in IDLE/DONE)
//   hidden_input_vector - N signed hidden values, element i at [i*hidden_neuron_size +: hidden_neuron_size]
//   weight_vector       - N*M signed weights, weight (j,i) at [(j*N+i)*weight_size +: weight_size]
//   bias_vector         - M signed biases, bias j at [j*bias_size +: bias_size]
//   busy                - high while in MAC or BIAS
//   done                - one-cycle completion pulse (the DONE-entry cycle)
//   out_valid           - activation_vector holds a completed result
//   activation_vector   - M signed results, output j at [j*acc_size +: acc_size]
module layer_2_mac_sequencer #(
  parameter int weight_size              = 5,
  parameter int bias_size                = 6,
  parameter int number_of_hidden_neurons = 5,
  parameter int number_of_outputs        = 2,
  parameter int hidden_neuron_size       = 54,
  parameter int acc_size                 = 64
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   start,
  input  logic [number_of_hidden_neurons*hidden_neuron_size-1:0] hidden_input_vector,
  input  logic [number_of_hidden_neurons*number_of_outputs*weight_size-1:0] weight_vector,
  input  logic [number_of_outputs*bias_size-1:0]                 bias_vector,
  output logic                                                   busy,
  output logic                                                   done,
  output logic                                                   out_valid,
  output logic [number_of_outputs*acc_size-1:0]                  activation_vector
);

  localparam int N  = number_of_hidden_neurons;
  localparam int M  = number_of_outputs;
  localparam int PW = weight_size + hidden_neuron_size;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int JW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_t;

  state_t                                  state;
  logic [N*hidden_neuron_size-1:0]         hidden_reg;
  logic [N*M*weight_size-1:0]              weight_reg;
  logic [M*bias_size-1:0]                  bias_reg;
  logic signed [acc_size-1:0]              acc;
  logic [IW-1:0]                           i_cnt;
  logic [JW-1:0]                           j_cnt;
  logic [M*acc_size-1:0]                   staging;

  logic signed [hidden_neuron_size-1:0]    hidden_sel;
  logic signed [weight_size-1:0]           weight_sel;
  logic signed [bias_size-1:0]             bias_sel;
  logic signed [PW-1:0]                    product;
  logic signed [acc_size-1:0]              product_ext;
  logic signed [acc_size-1:0]              bias_ext;
  logic signed [acc_size-1:0]              biased_sum;
  logic signed [acc_size-1:0]              slot_value;
  logic [M*acc_size-1:0]                   staging_next;
  logic                                    last_i;
  logic                                    last_j;

  // Operand selection and the single shared multiplier. staging_next is
  // the staging array with slot j already replaced. The last BIAS cycle
  // can then publish every slot, including the one being written, in one
  // atomic copy.
  always_comb begin
    hidden_sel   = hidden_reg[int'(i_cnt)*hidden_neuron_size +: hidden_neuron_size];
    weight_sel   = weight_reg[(int'(j_cnt)*N + int'(i_cnt))*weight_size +: weight_size];
    bias_sel     = bias_reg[int'(j_cnt)*bias_size +: bias_size];
    product      = hidden_sel * weight_sel;
    product_ext  = acc_size'(product);
    bias_ext     = acc_size'(bias_sel);
    biased_sum   = acc + bias_ext;
`ifdef LAYER2_RELU_EN
    slot_value   = biased_sum[acc_size-1] ? '0 : biased_sum;
`else
    slot_value   = biased_sum;
`endif
    staging_next = staging;
    staging_next[int'(j_cnt)*acc_size +: acc_size] = slot_value;
    last_i       = (i_cnt == IW'(N-1));
    last_j       = (j_cnt == JW'(M-1));
  end

  // Main sequencer. All outputs are registered here. start is only looked
  // at in IDLE/DONE, so it is ignored while busy. The input vectors are
  // sampled only on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      hidden_reg        <= '0;
      weight_reg        <= '0;
      bias_reg          <= '0;
      acc               <= '0;
      i_cnt             <= '0;
      j_cnt             <= '0;
      staging           <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      out_valid         <= 1'b0;
      activation_vector <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            hidden_reg <= hidden_input_vector;
            weight_reg <= weight_vector;
            bias_reg   <= bias_vector;
            acc        <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            busy       <= 1'b1;
            out_valid  <= 1'b0;
            state      <= MAC;
          end else begin
            state <= IDLE;
          end
        end
        MAC: begin
          acc <= acc + product_ext;
          if (last_i) begin
            i_cnt <= '0;
            state <= BIAS;
          end else begin
            i_cnt <= i_cnt + IW'(1);
          end
        end
        BIAS: begin
          staging <= staging_next;
          acc     <= '0;
          if (!last_j) begin
            j_cnt <= j_cnt + JW'(1);
            i_cnt <= '0;
            state <= MAC;
          end else begin
            activation_vector <= staging_next;
            done              <= 1'b1;
            out_valid         <= 1'b1;
            busy              <= 1'b0;
            state             <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_2_mac_sequencer.sv
// tb_layer_2_mac_sequencer
//
// Self-checking bench for layer_2_mac_sequencer with default parameters.
// Expected activation vectors come from a 64-bit behavioural model of the
// layer. They are pushed to a queue when a start is accepted and popped
// when done is seen. Cycle 1 is the cycle that begins at the edge which
// samples start, so done is due in cycle M*(N+1)+1.
// Optional feature: compile with LAYER2_RELU_EN defined to check the ReLU
// variant. The model applies the same clamp.
module tb_layer_2_mac_sequencer;

  localparam int W = 5;
  localparam int B = 6;
  localparam int N = 5;
  localparam int M = 2;
  localparam int H = 54;
  localparam int A = 64;
  localparam int LAT = M*(N+1)+1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [N*H-1:0]   hidden_input_vector = '0;
  logic [N*M*W-1:0] weight_vector = '0;
  logic [M*B-1:0]   bias_vector = '0;
  logic             busy;
  logic             done;
  logic             out_valid;
  logic [M*A-1:0]   activation_vector;

  layer_2_mac_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .hidden_input_vector (hidden_input_vector),
    .weight_vector       (weight_vector),
    .bias_vector         (bias_vector),
    .busy                (busy),
    .done                (done),
    .out_valid           (out_valid),
    .activation_vector   (activation_vector)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [M*A-1:0]  exp_q[$];
  logic signed [H-1:0] hid [N];
  logic signed [W-1:0] wgt [M][N];
  logic signed [B-1:0] bia [M];

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%h), expected %0d (0x%h)",
               tag, $signed(actual), actual, $signed(expected), expected);
    end
  endtask

  // Behavioural model of one evaluation using 64-bit arithmetic.
  function automatic logic [M*A-1:0] modelResult();
    logic [M*A-1:0] r;
    longint s;
    r = '0;
    for (int j = 0; j < M; j++) begin
      s = longint'(bia[j]);
      for (int i = 0; i < N; i++)
        s += longint'(hid[i]) * longint'(wgt[j][i]);
`ifdef LAYER2_RELU_EN
      if (s < 0) s = 0;
`endif
      r[j*A +: A] = s;
    end
    return r;
  endfunction

  task automatic packInputs();
    for (int i = 0; i < N; i++)
      hidden_input_vector[i*H +: H] = hid[i];
    for (int j = 0; j < M; j++) begin
      bias_vector[j*B +: B] = bia[j];
      for (int i = 0; i < N; i++)
        weight_vector[(j*N+i)*W +: W] = wgt[j][i];
    end
  endtask

  task automatic fillUniform(input longint h, input int w, input int b0, input int b1);
    for (int i = 0; i < N; i++) hid[i] = H'(h);
    for (int j = 0; j < M; j++)
      for (int i = 0; i < N; i++) wgt[j][i] = W'(w);
    bia[0] = B'(b0);
    bia[1] = B'(b1);
  endtask

  task automatic fillRandom();
    longint v;
    for (int i = 0; i < N; i++) begin
      v = longint'($urandom) - 64'sd2147483648;
      hid[i] = H'(v * 1000);
    end
    for (int j = 0; j < M; j++) begin
      bia[j] = B'($urandom_range(0, 63));
      for (int i = 0; i < N; i++) wgt[j][i] = W'($urandom_range(0, 31));
    end
  endtask

  // Drives the current arrays, pulses start across one edge (optionally
  // leaving it high) and pushes the expected result. Returns #1 after the
  // accepting edge, i.e. in cycle 1.
  task automatic applyStimulus(input bit hold_start);
    packInputs();
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    exp_q.push_back(modelResult());
  endtask

  // Steps cycles until done, bounded, then compares latency, flags and the
  // popped expected result.
  task automatic waitDone(input string tag, input int start_cyc);
    int cyc;
    bit seen;
    bit ov_bad;
    bit busy_bad;
    logic [M*A-1:0] exp_v;
    cyc = start_cyc;
    seen = 1'b0;
    ov_bad = 1'b0;
    busy_bad = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (out_valid !== 1'b0) ov_bad = 1'b1;
        if (busy !== 1'b1) busy_bad = 1'b1;
      end
    end
    checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      checkOutput({tag, "_latency"}, 64'(cyc), 64'(LAT));
      checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd1);
      checkOutput({tag, "_busy_low_in_done"}, 64'(busy), 64'd0);
      checkOutput({tag, "_out_valid_low_while_busy"}, 64'(ov_bad), 64'd0);
      checkOutput({tag, "_busy_high_while_running"}, 64'(busy_bad), 64'd0);
    end
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      if (seen)
        for (int j = 0; j < M; j++)
          checkOutput($sformatf("%s_out%0d", tag, j), activation_vector[j*A +: A], exp_v[j*A +: A]);
    end
  endtask

  task automatic countDones(input string tag, input int cycles);
    int n;
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n++;
    end
    checkOutput({tag, "_no_extra_done"}, 64'(n), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [M*A-1:0] held;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_act0", activation_vector[0 +: A], 64'd0);
    checkOutput("reset_act1", activation_vector[A +: A], 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All ones, zero bias: both outputs are 5
    fillUniform(1, 1, 0, 0);
    applyStimulus(1'b0);
    checkOutput("ones_busy_c1", 64'(busy), 64'd1);
    waitDone("ones", 1);
    held = activation_vector;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ones_hold_act", activation_vector[0 +: A], held[0 +: A]);
    checkOutput("ones_hold_out_valid", 64'(out_valid), 64'd1);
    checkOutput("ones_idle_done_low", 64'(done), 64'd0);

    // Negative hidden, mixed biases (ReLU variant clamps out0)
    fillUniform(-3, 2, -5, 31);
    applyStimulus(1'b0);
    checkOutput("neg_out_valid_fall", 64'(out_valid), 64'd0);
    waitDone("neg", 1);

    // Largest positive hidden times most negative weight, everything else 0
    fillUniform(0, 0, 0, 0);
    hid[0] = H'(64'sd9007199254740991);
    wgt[0][0] = W'(-16);
    applyStimulus(1'b0);
    waitDone("maxpos", 1);

    // Most negative hidden and weight everywhere: largest positive sums
    fillUniform(-64'sd9007199254740992, -16, -32, 31);
    applyStimulus(1'b0);
    waitDone("maxneg", 1);

    // Random patterns
    for (int t = 0; t < 3; t++) begin
      fillRandom();
      applyStimulus(1'b0);
      waitDone($sformatf("rand%0d", t), 1);
    end

    // start pulsed 4 cycles after acceptance with new inputs: ignored
    fillUniform(7, 3, 1, -2);
    applyStimulus(1'b0);
    repeat (3) @(posedge clk);
    #1;
    fillUniform(-100, -7, 20, -20);
    packInputs();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("ignore", 5);
    countDones("ignore", 20);

    // Back-to-back: start held through the done cycle
    fillUniform(2, 5, 3, -9);
    applyStimulus(1'b1);
    fillUniform(-11, 9, -1, 17);
    packInputs();
    waitDone("b2b_first", 1);
    exp_q.push_back(modelResult());
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_out_valid_fall", 64'(out_valid), 64'd0);
    checkOutput("b2b_busy_c1", 64'(busy), 64'd1);
    waitDone("b2b_second", 1);

    // Reset asserted in cycle 6 of an evaluation
    fillUniform(4, 4, 4, 4);
    applyStimulus(1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_done", 64'(done), 64'd0);
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_act0", activation_vector[0 +: A], 64'd0);
    checkOutput("midreset_act1", activation_vector[A +: A], 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    countDones("midreset", 20);
    checkOutput("midreset_idle_busy", 64'(busy), 64'd0);

    // Recovery after reset
    fillRandom();
    applyStimulus(1'b0);
    waitDone("recover", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
